// File: rtl/col_conv_pe_if.sv
// col_conv_pe_if: pixel-column stream, result stream and weight-config signals of col_conv_pe
interface col_conv_pe_if #(
  parameter int DATA_W = 8,
  parameter int KERNEL_H = 7,
  parameter int COEF_W = 5
);
  logic i_vld;
  logic i_eof;
  logic [KERNEL_H*DATA_W-1:0] i_data;
  logic o_rdy;
  logic o_vld;
  logic o_eof;
  logic [DATA_W-1:0] o_data;
  logic i_rdy;
  logic i_cfg_we;
  logic [$clog2(KERNEL_H)-1:0] i_cfg_idx;
  logic [COEF_W-1:0] i_cfg_wt;
  logic i_cfg_commit;
  logic o_cfg_pend;
  modport slave (
    input i_vld, i_eof, i_data, i_rdy, i_cfg_we, i_cfg_idx, i_cfg_wt, i_cfg_commit,
    output o_rdy, o_vld, o_eof, o_data, o_cfg_pend
  );
  modport master (
    output i_vld, i_eof, i_data, i_rdy, i_cfg_we, i_cfg_idx, i_cfg_wt, i_cfg_commit,
    input o_rdy, o_vld, o_eof, o_data, o_cfg_pend
  );
endinterface

// File: rtl/col_conv_pe.sv
// col_conv_pe: column dot-product PE with 2-entry skid, elastic pipe and drained shadow-weight swap
module col_conv_pe #(
  parameter int DATA_W = 8,
  parameter int KERNEL_H = 7,
  parameter int COEF_W = 5,
  parameter logic [KERNEL_H*COEF_W-1:0] WEIGHTS = {5'd7, 5'd26, 5'd5, 5'd28, 5'd3, 5'd30, 5'd1},
  parameter int NORM_SHIFT = 5,
  parameter int PIPE_STAGES = 3
) (
  input logic i_clk,
  input logic i_rst,
  col_conv_pe_if.slave bus
);
  localparam int IW = $clog2(KERNEL_H);
  localparam int AW = DATA_W + COEF_W + IW + 1;
  localparam int VW = KERNEL_H * DATA_W;
  localparam logic [AW:0] RND = (AW + 1)'(1) << (NORM_SHIFT - 1);
  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
  state_t state;
  logic signed [COEF_W-1:0] act [KERNEL_H];
  logic signed [COEF_W-1:0] shd [KERNEL_H];
  logic [VW-1:0] sk_d [2];
  logic [1:0] sk_e;
  logic [1:0] cnt, cnt_n;
  logic signed [AW-1:0] st_acc [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] st_vld, st_eof, adv;
  logic acc_in, pop, push, src_vld, src_e, wi;
  logic [VW-1:0] src_d;
  logic signed [AW-1:0] src_acc;
  logic signed [AW:0] rnd;
  assign acc_in = bus.i_vld && bus.o_rdy;
  assign src_vld = cnt != 2'd0 || acc_in;
  assign src_d = cnt != 2'd0 ? sk_d[0] : bus.i_data;
  assign src_e = cnt != 2'd0 ? sk_e[0] : bus.i_eof;
  assign pop = adv[0] && cnt != 2'd0;
  assign push = acc_in && (cnt != 2'd0 || !adv[0]);
  assign cnt_n = cnt - {1'b0, pop} + {1'b0, push};
  assign wi = (cnt - {1'b0, pop}) != 2'd0;
  assign rnd = ($signed({st_acc[PIPE_STAGES-1][AW-1], st_acc[PIPE_STAGES-1]}) + $signed(RND)) >>> NORM_SHIFT;
  assign bus.o_vld = st_vld[PIPE_STAGES-1];
  assign bus.o_eof = st_eof[PIPE_STAGES-1];
  assign bus.o_data = rnd[AW] ? '0 : (|rnd[AW-1:DATA_W] ? '1 : rnd[DATA_W-1:0]);
  always_comb begin : adv_chain
    logic a;
    a = !st_vld[PIPE_STAGES-1] || bus.i_rdy;
    adv = '0;
    adv[PIPE_STAGES-1] = a;
    for (int s = PIPE_STAGES - 2; s >= 0; s--) begin
      a = !st_vld[s] || a;
      adv[s] = a;
    end
  end
  always_comb begin
    src_acc = '0;
    for (int k = 0; k < KERNEL_H; k++)
      src_acc += AW'($signed({1'b0, src_d[k*DATA_W +: DATA_W]})) * AW'(act[k]);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RUN;
      bus.o_rdy <= 1'b0;
      bus.o_cfg_pend <= 1'b0;
      cnt <= '0;
      st_vld <= '0;
      st_eof <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) st_acc[s] <= '0;
      for (int k = 0; k < KERNEL_H; k++) begin
        act[k] <= WEIGHTS[k*COEF_W +: COEF_W];
        shd[k] <= WEIGHTS[k*COEF_W +: COEF_W];
      end
    end else begin
      if (bus.i_cfg_we && 32'(bus.i_cfg_idx) < KERNEL_H) shd[bus.i_cfg_idx] <= bus.i_cfg_wt;
      if (pop) begin
        sk_d[0] <= sk_d[1];
        sk_e[0] <= sk_e[1];
      end
      if (push) begin
        sk_d[wi] <= bus.i_data;
        sk_e[wi] <= bus.i_eof;
      end
      cnt <= cnt_n;
      if (adv[0]) begin
        st_vld[0] <= src_vld;
        st_eof[0] <= src_e;
        st_acc[0] <= src_acc;
      end
      for (int s = 1; s < PIPE_STAGES; s++)
        if (adv[s]) begin
          st_vld[s] <= st_vld[s-1];
          st_eof[s] <= st_eof[s-1];
          st_acc[s] <= st_acc[s-1];
        end
      bus.o_rdy <= (state == SWAP || (state == RUN && !bus.i_cfg_commit)) && cnt_n != 2'd2;
      if (state == RUN && bus.i_cfg_commit) begin
        state <= DRAIN;
        bus.o_cfg_pend <= 1'b1;
      end
      if (state == DRAIN && cnt == 2'd0 && st_vld == '0) begin
        state <= SWAP;
        act <= shd;
      end
      if (state == SWAP) begin
        state <= RUN;
        bus.o_cfg_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_col_conv_pe.sv
// tb_col_conv_pe: randomized scoreboard bench for col_conv_pe against a plain-arithmetic reference
module tb_col_conv_pe;
  localparam int DW = 8;
  localparam int KH = 7;
  localparam int CW = 5;
  localparam int NS = 5;
  localparam int VW = KH * DW;
  localparam int IW = $clog2(KH);
  localparam int MAXV = (1 << DW) - 1;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  col_conv_pe_if #(.DATA_W(DW), .KERNEL_H(KH), .COEF_W(CW)) bus ();
  col_conv_pe dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
  always #5 i_clk = ~i_clk;
  int n_tests = 0;
  int n_fail = 0;
  int rdy_mode = 0;
  int n_out = 0;
  int n_eof = 0;
  int m_act [KH];
  int m_shd [KH];
  logic [DW:0] exp_q [$];
  logic [DW:0] mon_e;
  logic stall_prev = 1'b0;
  logic pend_prev = 1'b0;
  logic [DW-1:0] stall_d;
  logic stall_e;
  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask
  task automatic reset_model();
    int def [KH] = '{1, -2, 3, -4, 5, -6, 7};
    for (int k = 0; k < KH; k++) begin
      m_act[k] = def[k];
      m_shd[k] = def[k];
    end
  endtask
  function automatic int model(input logic [VW-1:0] d);
    int s = 0;
    for (int k = 0; k < KH; k++) s += int'(d[k*DW +: DW]) * m_act[k];
    s = (s + (1 << (NS - 1))) >>> NS;
    return s < 0 ? 0 : (s > MAXV ? MAXV : s);
  endfunction
  function automatic logic [VW-1:0] fill(input int v);
    logic [VW-1:0] d;
    for (int k = 0; k < KH; k++) d[k*DW +: DW] = DW'(v);
    return d;
  endfunction
  function automatic logic [VW-1:0] one_tap(input int t, input int v);
    logic [VW-1:0] d = '0;
    d[t*DW +: DW] = DW'(v);
    return d;
  endfunction
  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] d;
    for (int k = 0; k < KH; k++) d[k*DW +: DW] = DW'($urandom);
    return d;
  endfunction
  always @(posedge i_clk) begin
    #1;
    case (rdy_mode)
      0: bus.i_rdy = 1'b1;
      1: bus.i_rdy = ~bus.i_rdy;
      2: bus.i_rdy = $urandom_range(0, 3) != 0;
      default: bus.i_rdy = 1'b0;
    endcase
  end
  always @(negedge i_clk) begin
    if (i_rst) begin
      stall_prev <= 1'b0;
      pend_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_vld", int'(bus.o_vld), 1);
        check("stall_data", int'(bus.o_data), int'(stall_d));
        check("stall_eof", int'(bus.o_eof), int'(stall_e));
      end
      if (pend_prev && !bus.o_cfg_pend) begin
        m_act = m_shd;
        check("drained_at_swap", exp_q.size(), 0);
      end
      if (bus.o_cfg_pend) check("rdy_low_while_pend", int'(bus.o_rdy), 0);
      if (bus.i_vld && bus.o_rdy) begin
        exp_q.push_back({DW'(model(bus.i_data)), bus.i_eof});
        check("outstanding_le5", int'(exp_q.size() <= 5), 1);
      end
      if (bus.o_vld && bus.i_rdy) begin
        n_out++;
        n_eof += int'(bus.o_eof);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got data %0d with no beat outstanding, expected none", bus.o_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_data", int'(bus.o_data), int'(mon_e[DW:1]));
          check("sb_eof", int'(bus.o_eof), int'(mon_e[0]));
        end
      end
      stall_prev <= bus.o_vld && !bus.i_rdy;
      stall_d <= bus.o_data;
      stall_e <= bus.o_eof;
      pend_prev <= bus.o_cfg_pend;
    end
  end
  task automatic sync();
    @(posedge i_clk);
    #1;
  endtask
  task automatic send(input logic [VW-1:0] d, input logic e);
    int t = 0;
    logic ok = 1'b0;
    bus.i_vld = 1'b1;
    bus.i_data = d;
    bus.i_eof = e;
    while (!ok && t < 300) begin
      @(negedge i_clk);
      ok = bus.o_rdy;
      t++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: o_rdy was 0 for %0d cycles, expected 1", t);
    end
    sync();
    bus.i_vld = 1'b0;
    bus.i_eof = 1'b0;
  endtask
  task automatic expect_out(input string name, input int want);
    int t = 0;
    while (!(bus.o_vld && bus.i_rdy) && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    check(name, bus.o_vld && bus.i_rdy ? int'(bus.o_data) : -1, want);
    sync();
  endtask
  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge i_clk);
      t++;
    end
    check(name, exp_q.size(), 0);
    sync();
  endtask
  task automatic wait_swap(input string name);
    int t = 0;
    while (bus.o_cfg_pend && t < 500) begin
      @(negedge i_clk);
      t++;
    end
    check(name, int'(bus.o_cfg_pend), 0);
    sync();
  endtask
  task automatic cfg_write(input int idx, input int w);
    bus.i_cfg_we = 1'b1;
    bus.i_cfg_idx = IW'(idx);
    bus.i_cfg_wt = CW'(w);
    if (idx < KH) m_shd[idx] = w;
    sync();
    bus.i_cfg_we = 1'b0;
  endtask
  task automatic commit();
    bus.i_cfg_commit = 1'b1;
    sync();
    bus.i_cfg_commit = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int nv;
    int np;
    int base;
    bus.i_vld = 1'b0;
    bus.i_eof = 1'b0;
    bus.i_data = '0;
    bus.i_rdy = 1'b1;
    bus.i_cfg_we = 1'b0;
    bus.i_cfg_idx = '0;
    bus.i_cfg_wt = '0;
    bus.i_cfg_commit = 1'b0;
    reset_model();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_o_vld", int'(bus.o_vld), 0);
    check("rst_o_rdy", int'(bus.o_rdy), 0);
    check("rst_o_pend", int'(bus.o_cfg_pend), 0);
    check("rst_o_data", int'(bus.o_data), 0);
    check("rst_o_eof", int'(bus.o_eof), 0);
    sync();
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("rdy_after_rst", int'(bus.o_rdy), 1);
    sync();
    send(fill(255), 1'b0);
    @(negedge i_clk);
    check("lat_c1_vld", int'(bus.o_vld), 0);
    @(negedge i_clk);
    check("lat_c2_vld", int'(bus.o_vld), 0);
    @(negedge i_clk);
    check("lat_c3_vld", int'(bus.o_vld), 1);
    check("all255_data", int'(bus.o_data), 32);
    check("all255_eof", int'(bus.o_eof), 0);
    sync();
    send(one_tap(6, 200), 1'b0);
    expect_out("tap6_200", 44);
    send(one_tap(5, 255), 1'b0);
    expect_out("tap5_neg_clamp", 0);
    wait_drain("drain_directed");
    rdy_mode = 1;
    base = n_out;
    for (int i = 0; i < 20; i++) send(rnd_vec(), 1'b0);
    wait_drain("drain_toggle");
    check("toggle_count", n_out - base, 20);
    rdy_mode = 0;
    base = n_eof;
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 5; i++) send(rnd_vec(), i == 5);
    wait_drain("drain_eof");
    check("eof_count", n_eof - base, 2);
    for (int k = 0; k < KH; k++) cfg_write(k, 15);
    send(fill(255), 1'b0);
    expect_out("shadow_isolated", 32);
    rdy_mode = 2;
    fork
      for (int i = 0; i < 12; i++) send(rnd_vec(), 1'b0);
      begin
        repeat (4) sync();
        commit();
      end
    join
    wait_swap("swap_mid");
    wait_drain("drain_mid");
    rdy_mode = 0;
    sync();
    send(fill(255), 1'b0);
    expect_out("post_swap_sat", 255);
    rdy_mode = 3;
    repeat (2) sync();
    for (int i = 0; i < 3; i++) send(rnd_vec(), 1'b0);
    commit();
    @(negedge i_clk);
    check("pend_set", int'(bus.o_cfg_pend), 1);
    sync();
    i_rst = 1'b1;
    exp_q.delete();
    reset_model();
    repeat (2) sync();
    rdy_mode = 0;
    i_rst = 1'b0;
    nv = 0;
    np = 0;
    repeat (10) begin
      @(negedge i_clk);
      nv += int'(bus.o_vld);
      np += int'(bus.o_cfg_pend);
    end
    check("no_vld_after_rst", nv, 0);
    check("no_pend_after_rst", np, 0);
    sync();
    send(fill(255), 1'b0);
    expect_out("rst_active_wts", 32);
    cfg_write(7, 0);
    commit();
    wait_swap("swap_after_rst");
    send(fill(255), 1'b0);
    expect_out("rst_shadow_wts", 32);
    rdy_mode = 2;
    fork
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
        send(rnd_vec(), $urandom_range(0, 7) == 0);
      end
      begin
        repeat (60) sync();
        for (int k = 0; k < KH; k++) cfg_write(k, int'($urandom_range(0, 31)) - 16);
        commit();
      end
    join
    wait_swap("swap_random");
    wait_drain("drain_random");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
